// File: rtl/rf_seq_if.sv
// rf_seq_if: request/response bus of the register-file sequencer.
// The master side offers requests and accepts responses; the slave side
// (rf_seq) accepts requests and returns the captured read values.
interface rf_seq_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_scr1;
  logic [AW-1:0] req_scr2;
  logic [AW-1:0] req_dest;
  logic [DW-1:0] req_wdata;
  logic          req_we;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data1;
  logic [DW-1:0] rsp_data2;

  modport master (
    output req_valid, req_scr1, req_scr2, req_dest, req_wdata, req_we, rsp_ready,
    input  req_ready, rsp_valid, rsp_data1, rsp_data2
  );

  modport slave (
    input  req_valid, req_scr1, req_scr2, req_dest, req_wdata, req_we, rsp_ready,
    output req_ready, rsp_valid, rsp_data1, rsp_data2
  );
endinterface

// File: rtl/rf_seq.sv
// rf_seq: sequences one read-two/write-one request against an external
// register file whose read outputs are registered.
// Default order: IDLE -> RD -> CAP -> (WR) -> RSP, so a read of the
// destination returns the value before the write.
// Optional macro RF_SEQ_WRFIRST_EN: IDLE -> (WR) -> RD -> CAP -> RSP, so a
// read of the destination returns the freshly written value. Latency is the
// same in both orders because the same states are visited.
module rf_seq #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          reset,
  rf_seq_if.slave       bus,
  output logic [AW-1:0] rf_scr1,
  output logic [AW-1:0] rf_scr2,
  output logic [AW-1:0] rf_dest,
  output logic [DW-1:0] rf_writeIn,
  output logic          rf_read_l,
  input  logic [DW-1:0] rf_readOut1,
  input  logic [DW-1:0] rf_readOut2
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    RSP  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          we_q, we_d;
  logic [AW-1:0] scr1_q, scr1_d;
  logic [AW-1:0] scr2_q, scr2_d;
  logic [AW-1:0] dest_q, dest_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] data1_q, data1_d;
  logic [DW-1:0] data2_q, data2_d;
  logic          req_ready_q, req_ready_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rf_read_l_q, rf_read_l_d;
  logic          accept;

  assign accept = bus.req_valid & req_ready_q;

  // The latched request drives the register-file address/data lines directly,
  // so they stay put from accept until the next accept (including in IDLE).
  assign rf_scr1       = scr1_q;
  assign rf_scr2       = scr2_q;
  assign rf_dest       = dest_q;
  assign rf_writeIn    = wdata_q;
  assign rf_read_l     = rf_read_l_q;
  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data1 = data1_q;
  assign bus.rsp_data2 = data2_q;

  // Next-state logic; outputs are derived from the next state so they are registered.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    scr1_d  = scr1_q;
    scr2_d  = scr2_q;
    dest_d  = dest_q;
    wdata_d = wdata_q;
    data1_d = data1_q;
    data2_d = data2_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d    = bus.req_we;
          scr1_d  = bus.req_scr1;
          scr2_d  = bus.req_scr2;
          dest_d  = bus.req_dest;
          wdata_d = bus.req_wdata;
`ifdef RF_SEQ_WRFIRST_EN
          state_d = bus.req_we ? WR : RD;
`else
          state_d = RD;
`endif
        end
      end
      RD: begin
        state_d = CAP;
      end
      CAP: begin
        data1_d = rf_readOut1;
        data2_d = rf_readOut2;
`ifdef RF_SEQ_WRFIRST_EN
        state_d = RSP;
`else
        state_d = we_q ? WR : RSP;
`endif
      end
      WR: begin
`ifdef RF_SEQ_WRFIRST_EN
        state_d = RD;
`else
        state_d = RSP;
`endif
      end
      RSP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RSP);
    rf_read_l_d = (state_d == WR);
  end

  // State and registered outputs; reset clears everything at once, which
  // also kills an in-progress write pulse without waiting for a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      scr1_q      <= '0;
      scr2_q      <= '0;
      dest_q      <= '0;
      wdata_q     <= '0;
      data1_q     <= '0;
      data2_q     <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rf_read_l_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      scr1_q      <= scr1_d;
      scr2_q      <= scr2_d;
      dest_q      <= dest_d;
      wdata_q     <= wdata_d;
      data1_q     <= data1_d;
      data2_q     <= data2_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rf_read_l_q <= rf_read_l_d;
    end
  end

endmodule

// File: tb/tb_rf_seq.sv
// tb_rf_seq: directed bench for rf_seq with an external register-file model
// and a transaction-level reference model checked every cycle.
module tb_rf_seq;
  localparam int DW = 32;
  localparam int AW = 5;
`ifdef RF_SEQ_WRFIRST_EN
  localparam bit WRFIRST = 1'b1;
`else
  localparam bit WRFIRST = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] rf_scr1, rf_scr2, rf_dest;
  logic [DW-1:0] rf_writeIn, rf_readOut1, rf_readOut2;
  logic          rf_read_l;

  int checks = 0;
  int errors = 0;

  rf_seq_if #(.DW(DW), .AW(AW)) bus ();

  rf_seq #(.DW(DW), .AW(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .rf_scr1     (rf_scr1),
    .rf_scr2     (rf_scr2),
    .rf_dest     (rf_dest),
    .rf_writeIn  (rf_writeIn),
    .rf_read_l   (rf_read_l),
    .rf_readOut1 (rf_readOut1),
    .rf_readOut2 (rf_readOut2)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(int a);
    return 32'hA500_0000 | DW'(a);
  endfunction

  task automatic checkOutput(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkCount(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // External register file: registered read outputs, write when rf_read_l is 1.
  logic [DW-1:0] rf_mem [32];
  bit            rf_init = 1'b0;
  always @(posedge clk) begin
    if (!rf_init) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= init_val(i);
      rf_init <= 1'b1;
    end else if (rf_read_l) begin
      rf_mem[rf_dest] <= rf_writeIn;
    end else begin
      rf_readOut1 <= rf_mem[rf_scr1];
      rf_readOut2 <= rf_mem[rf_scr2];
    end
  end

  // Reference model: one transaction at a time, results computed at accept
  // from an architectural register map, timing tracked as cycles since accept.
  logic [DW-1:0] wr_map [int];
  bit            m_live = 1'b0;
  bit            m_pend = 1'b0;
  bit            m_we = 1'b0;
  int            m_k = 0;
  int            m_lat = 3;
  int            m_wr_k = 3;
  int            m_dest = 0;
  logic [DW-1:0] m_old = '0;
  logic [DW-1:0] m_d1 = '0;
  logic [DW-1:0] m_d2 = '0;

  function automatic logic [DW-1:0] ref_rd(int a);
    return wr_map.exists(a) ? wr_map[a] : init_val(a);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      if (m_pend && m_we && m_k <= m_wr_k) wr_map[m_dest] = m_old;
      m_pend = 1'b0;
      m_live = 1'b0;
    end else if (!m_live) begin
      m_live = 1'b1;
    end else if (!m_pend) begin
      if (bus.req_valid) begin
        m_we   = bus.req_we;
        m_dest = int'(bus.req_dest);
        m_old  = ref_rd(m_dest);
        if (WRFIRST && m_we) wr_map[m_dest] = bus.req_wdata;
        m_d1 = ref_rd(int'(bus.req_scr1));
        m_d2 = ref_rd(int'(bus.req_scr2));
        if (!WRFIRST && m_we) wr_map[m_dest] = bus.req_wdata;
        m_lat  = m_we ? 4 : 3;
        m_wr_k = WRFIRST ? 1 : 3;
        m_k    = 1;
        m_pend = 1'b1;
      end
    end else if (m_k >= m_lat && bus.rsp_ready) begin
      m_pend = 1'b0;
    end else begin
      m_k++;
    end
  end

  // Compare the DUT against the model on every falling edge.
  always @(negedge clk) begin
    checkOutput("req_ready", DW'(bus.req_ready), DW'(m_live && !m_pend));
    checkOutput("rsp_valid", DW'(bus.rsp_valid), DW'(m_pend && m_k >= m_lat));
    checkOutput("rf_read_l", DW'(rf_read_l), DW'(m_pend && m_we && m_k == m_wr_k));
    if (m_pend && m_k >= m_lat) begin
      checkOutput("rsp_data1", bus.rsp_data1, m_d1);
      checkOutput("rsp_data2", bus.rsp_data2, m_d2);
    end
  end

  // Accept monitor used for throughput measurement.
  int cyc = 0;
  int acc_q [$];
  always @(posedge clk) begin
    cyc++;
    if (!reset && bus.req_valid && bus.req_ready) acc_q.push_back(cyc);
  end

  // Issue one request, scramble the request fields after accept, and observe
  // the response; rsp_ready is withheld for 'hold' response cycles.
  task automatic applyStimulus(input bit we, input logic [AW-1:0] s1, input logic [AW-1:0] s2,
                               input logic [AW-1:0] d, input logic [DW-1:0] wd, input int hold,
                               output int first_k, output int rd_cnt, output int rd_in_rsp,
                               output int rdy_in_rsp, output int vcount,
                               output logic [DW-1:0] d1, output logic [DW-1:0] d2, output bit stable);
    int  guard;
    int  k;
    bit  done;
    first_k = -1; rd_cnt = 0; rd_in_rsp = 0; rdy_in_rsp = 0; vcount = 0;
    d1 = '0; d2 = '0; stable = 1'b1;
    @(negedge clk);
    bus.req_we = we; bus.req_scr1 = s1; bus.req_scr2 = s2;
    bus.req_dest = d; bus.req_wdata = wd; bus.req_valid = 1'b1;
    bus.rsp_ready = (hold == 0);
    guard = 0;
    while (!bus.req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkCount("accept_wait", int'(bus.req_ready), 1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'($urandom);
    bus.req_scr1  = AW'($urandom);
    bus.req_scr2  = AW'($urandom);
    bus.req_dest  = AW'($urandom);
    bus.req_wdata = DW'($urandom);
    k = 0;
    done = 1'b0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
      if (rf_read_l) rd_cnt++;
      if (bus.rsp_valid) begin
        vcount++;
        if (first_k < 0) begin
          first_k = k;
          d1 = bus.rsp_data1;
          d2 = bus.rsp_data2;
        end else if (bus.rsp_data1 !== d1 || bus.rsp_data2 !== d2) begin
          stable = 1'b0;
        end
        if (rf_read_l) rd_in_rsp++;
        if (bus.req_ready) rdy_in_rsp++;
        if (vcount > hold) begin
          bus.rsp_ready = 1'b1;
          @(posedge clk);
          #1;
          done = 1'b1;
        end
      end
    end
    checkCount("response_wait", int'(done), 1);
    bus.rsp_ready = 1'b0;
  endtask

  int            fk, rc, rir, ryr, vc, guard;
  logic [DW-1:0] r1, r2;
  bit            st;

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_scr1 = '0; bus.req_scr2 = '0;
    bus.req_dest = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b0;

    // Reset state.
    @(negedge clk);
    checkOutput("rst_req_ready", DW'(bus.req_ready), '0);
    checkOutput("rst_rsp_valid", DW'(bus.rsp_valid), '0);
    checkOutput("rst_rf_read_l", DW'(rf_read_l), '0);
    checkOutput("rst_rsp_data1", bus.rsp_data1, '0);
    checkOutput("rst_rf_writeIn", rf_writeIn, '0);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rel_req_ready_low", DW'(bus.req_ready), '0);
    @(posedge clk);
    #1;
    checkOutput("rel_req_ready_high", DW'(bus.req_ready), 32'd1);

    // Write 1 to r0 while reading r0/r4.
    applyStimulus(1'b1, 5'd0, 5'd4, 5'd0, 32'h0000_0001, 0, fk, rc, rir, ryr, vc, r1, r2, st);
    checkCount("w_r0_latency", fk, 4);
    checkCount("w_r0_wr_pulses", rc, 1);
    checkOutput("w_r0_data1", r1, WRFIRST ? 32'h0000_0001 : 32'hA500_0000);
    checkOutput("w_r0_data2", r2, 32'hA500_0004);

    // Write all-ones to r4, then a read-only request of r0/r4.
    applyStimulus(1'b1, 5'd0, 5'd0, 5'd4, 32'hFFFF_FFFF, 0, fk, rc, rir, ryr, vc, r1, r2, st);
    checkCount("w_r4_latency", fk, 4);
    applyStimulus(1'b0, 5'd0, 5'd4, 5'd9, 32'h5555_5555, 0, fk, rc, rir, ryr, vc, r1, r2, st);
    checkCount("rd_latency", fk, 3);
    checkCount("rd_wr_pulses", rc, 0);
    checkOutput("rd_data1", r1, 32'h0000_0001);
    checkOutput("rd_data2", r2, 32'hFFFF_FFFF);

    // Read and write the same register in one request.
    applyStimulus(1'b1, 5'd14, 5'd31, 5'd14, 32'hDEAD_BEEF, 0, fk, rc, rir, ryr, vc, r1, r2, st);
    checkOutput("raw_data1", r1, WRFIRST ? 32'hDEAD_BEEF : 32'hA500_000E);
    checkOutput("raw_data2", r2, 32'hA500_001F);

    // Response held off for 5 cycles.
    applyStimulus(1'b0, 5'd14, 5'd4, 5'd3, 32'h0, 5, fk, rc, rir, ryr, vc, r1, r2, st);
    checkCount("hold_valid_cycles", vc, 6);
    checkCount("hold_stable", int'(st), 1);
    checkCount("hold_no_wr_pulse", rir, 0);
    checkCount("hold_no_ready", ryr, 0);
    checkOutput("hold_data1", r1, 32'hDEAD_BEEF);

    // Reset in the middle of the write cycle.
    @(negedge clk);
    bus.req_we = 1'b1; bus.req_scr1 = 5'd20; bus.req_scr2 = 5'd20;
    bus.req_dest = 5'd20; bus.req_wdata = 32'h1234_5678; bus.req_valid = 1'b1; bus.rsp_ready = 1'b1;
    guard = 0;
    while (!bus.req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    guard = 0;
    while (!rf_read_l && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    checkCount("mid_wr_seen", int'(rf_read_l), 1);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("mid_wr_rf_read_l", DW'(rf_read_l), '0);
    checkOutput("mid_wr_rsp_valid", DW'(bus.rsp_valid), '0);
    checkOutput("mid_wr_req_ready", DW'(bus.req_ready), '0);
    checkOutput("mid_wr_rf_dest", DW'(rf_dest), '0);
    checkOutput("mid_wr_rsp_data2", bus.rsp_data2, '0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("mid_wr_ready_after", DW'(bus.req_ready), 32'd1);
    applyStimulus(1'b0, 5'd20, 5'd0, 5'd0, 32'h0, 0, fk, rc, rir, ryr, vc, r1, r2, st);
    checkOutput("dropped_write_r20", r1, 32'hA500_0014);

    // Back-to-back read-only requests with rsp_ready held high.
    bus.rsp_ready = 1'b1;
    acc_q.delete();
    for (int i = 0; i < 4; i++) begin
      guard = 0;
      @(negedge clk);
      while (!bus.req_ready && guard < 20) begin
        @(negedge clk);
        guard++;
      end
      bus.req_we = 1'b0; bus.req_scr1 = AW'(i + 1); bus.req_scr2 = AW'(31 - i);
      bus.req_dest = AW'(i); bus.req_wdata = 32'h0; bus.req_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
    repeat (6) @(negedge clk);
    checkCount("b2b_accepts", acc_q.size(), 4);
    if (acc_q.size() == 4) begin
      for (int i = 0; i < 3; i++) checkCount("b2b_gap", acc_q[i + 1] - acc_q[i], 4);
    end
    bus.rsp_ready = 1'b0;

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
